// File: rtl/mp_add_sequencer.sv
// ---------------------------------------------------------------------------
// mp_add_sequencer
//
// Purpose:
//   Multi-precision add controller built around one external WIDTH-bit ripple
//   adder. The controller feeds the adder and also consumes its output. It
//   latches two WIDTH*WORDS-bit operands and presents them to the adder one
//   slice per cycle, least significant slice first. Each slice's carry-out
//   becomes the next slice's carry-in. The controller assembles the full-width
//   sum, the final carry-out and the two's-complement overflow flag. This lets
//   32/64-bit additions share a single 16-bit adder.
//
// Parameters:
//   WIDTH   slice width; must match the attached adder's a/b/sum width
//   WORDS   number of slices (>= 2); operand/result width is WIDTH*WORDS
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   request, sampled only while idle
//   op_a      in   operand A, captured on an accepted start
//   op_b      in   operand B, captured on an accepted start
//   cin_in    in   initial carry-in, captured on an accepted start
//   add_a     out  current slice of A to the adder (0 outside RUN)
//   add_b     out  current slice of B to the adder (0 outside RUN)
//   add_cin   out  running carry to the adder (0 outside RUN)
//   add_sum   in   slice sum from the adder
//   add_cout  in   slice carry-out from the adder
//   busy      out  high while a run is in progress or completing (RUN, DONE)
//   done      out  one-cycle pulse, result/cout/ovf valid
//   result    out  full-width sum, held until the next accepted start
//   cout      out  final carry-out, held with result
//   ovf       out  signed overflow of the full-width add, held with result
// ---------------------------------------------------------------------------
module mp_add_sequencer #(
  parameter int WIDTH = 16,
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [WIDTH*WORDS-1:0]   op_a,
  input  logic [WIDTH*WORDS-1:0]   op_b,
  input  logic                     cin_in,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_cin,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_cout,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH*WORDS-1:0]   result,
  output logic                     cout,
  output logic                     ovf
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               crr;
  logic [WIDTH-1:0]   a_words [WORDS];
  logic [WIDTH-1:0]   b_words [WORDS];

  // Sign bits of the latched operands, used for the overflow decision on
  // the final slice.
  logic               a_msb;
  logic               b_msb;

  assign a_msb = a_words[WORDS-1][WIDTH-1];
  assign b_msb = b_words[WORDS-1][WIDTH-1];

  // The adder is driven purely from registered state. Outside RUN it sees
  // zeros, so it stays quiescent between operations.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_words[idx];
      add_b   = b_words[idx];
      add_cin = crr;
    end
  end

  // Control FSM and datapath registers. One slice is retired per RUN cycle.
  // The last slice also produces the final carry-out and overflow. DONE lasts
  // exactly one cycle, and busy falls as the FSM re-enters IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      crr    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      for (int w = 0; w < WORDS; w++) begin
        a_words[w] <= '0;
        b_words[w] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int w = 0; w < WORDS; w++) begin
              a_words[w] <= op_a[w*WIDTH +: WIDTH];
              b_words[w] <= op_b[w*WIDTH +: WIDTH];
            end
            crr    <= cin_in;
            idx    <= '0;
            result <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end

        RUN: begin
          for (int w = 0; w < WORDS; w++) begin
            if (idx == IDX_W'(w)) begin
              result[w*WIDTH +: WIDTH] <= add_sum;
            end
          end
          crr <= add_cout;
          if (idx == LAST_IDX) begin
            cout  <= add_cout;
            ovf   <= (a_msb == b_msb) && (add_sum[WIDTH-1] != a_msb);
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp_add_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mp_add_sequencer
//
// Bench for mp_add_sequencer with WIDTH=16 and WORDS=4. A behavioural 16-bit
// ripple adder stands in for the external adder. Expected results come from
// a full-width reference model. They are queued when a start is issued and
// compared when the DUT pulses done.
// ---------------------------------------------------------------------------
module tb_mp_add_sequencer;

  localparam int WIDTH = 16;
  localparam int WORDS = 4;
  localparam int N     = WIDTH * WORDS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [N-1:0]     op_a = '0;
  logic [N-1:0]     op_b = '0;
  logic             cin_in = 1'b0;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             busy;
  logic             done;
  logic [N-1:0]     result;
  logic             cout;
  logic             ovf;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         c;
    logic         v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mp_add_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .cin_in   (cin_in),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .ovf      (ovf)
  );

  // Stand-in for the external 16-bit adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    logic [N:0] t;
    exp_t e;
    t     = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
    e.sum = t[N-1:0];
    e.c   = t[N];
    e.v   = (a[N-1] == b[N-1]) && (t[N-1] != a[N-1]);
    return e;
  endfunction

  // Counts negedges until done is seen; returns -1 if it never arrives.
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 50);
    if (!done) cyc = -1;
  endtask

  // Pops the oldest expectation and compares it to the held outputs.
  task automatic score(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s scoreboard empty at done", name);
    end else begin
      e = sb.pop_front();
      if (result !== e.sum) begin
        errors++;
        $display("[TB] FAIL %s result got %h want %h", name, result, e.sum);
      end
      checks++;
      if (cout !== e.c) begin
        errors++;
        $display("[TB] FAIL %s cout got %b want %b", name, cout, e.c);
      end
      checks++;
      if (ovf !== e.v) begin
        errors++;
        $display("[TB] FAIL %s ovf got %b want %b", name, ovf, e.v);
      end
    end
  endtask

  // Full single operation starting from IDLE at a negedge.
  task automatic run_add(input logic [N-1:0] a, input logic [N-1:0] b, input logic c, input string name);
    int cyc;
    op_a = a; op_b = b; cin_in = c; start = 1'b1;
    sb.push_back(model(a, b, c));
    @(negedge clk);
    start = 1'b0;
    op_a = ~a; op_b = ~b; cin_in = ~c;
    checks++;
    if (busy !== 1'b1 || result !== '0) begin
      errors++;
      $display("[TB] FAIL %s run_entry busy=%b result=%h want busy=1 result=0", name, busy, result);
    end
    checks++;
    if (add_a !== a[WIDTH-1:0] || add_b !== b[WIDTH-1:0] || add_cin !== c) begin
      errors++;
      $display("[TB] FAIL %s slice0 a=%h b=%h cin=%b want a=%h b=%h cin=%b",
               name, add_a, add_b, add_cin, a[WIDTH-1:0], b[WIDTH-1:0], c);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== WORDS) begin
      errors++;
      $display("[TB] FAIL %s latency got %0d want %0d", name, cyc, WORDS);
    end
    if (cyc > 0) score(name);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s after_done done=%b busy=%b want 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs busy=%b done=%b result=%h cout=%b ovf=%b want all 0",
               busy, done, result, cout, ovf);
    end
    checks++;
    if (add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_adder a=%h b=%h cin=%b want 0", add_a, add_b, add_cin);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || add_a !== '0) begin
      errors++;
      $display("[TB] FAIL idle_quiet busy=%b add_a=%h want 0 0", busy, add_a);
    end
  endtask

  task automatic test_add_vectors();
    run_add(64'h3, 64'h2, 1'b0, "small");
    run_add(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "all_ones");
    run_add(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, "carry_s0_s1");
    run_add(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, "cin_wrap");
    run_add(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, "pos_ovf");
    run_add(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, "neg_ovf");
    for (int i = 0; i < 3; i++) begin
      run_add({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_ignore_start();
    int   dones;
    exp_t e;
    e = model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    sb.push_back(e);
    op_a = 64'h1234_5678_9ABC_DEF0; op_b = 64'h0FED_CBA9_8765_4321; cin_in = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op_a = 64'h1111_1111_1111_1111; op_b = 64'h2222_2222_2222_2222; cin_in = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int k = 0; k < 14; k++) begin
      if (done) begin
        dones++;
        if (dones == 1) begin
          score("ignore_start");
          op_a = 64'h5555; op_b = 64'h6666; start = 1'b1;
        end
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("[TB] FAIL done_count got %0d want 1", dones);
    end
    checks++;
    if (result !== e.sum || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL result_held result=%h busy=%b want %h 0", result, busy, e.sum);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    op_a = 64'h0000_0001_0000_FFFF; op_b = 64'h0000_0000_0000_0001; cin_in = 1'b0;
    sb.push_back(model(op_a, op_b, cin_in));
    start = 1'b1;
    @(negedge clk);
    wait_done(cyc);
    checks++;
    if (cyc !== WORDS) begin
      errors++;
      $display("[TB] FAIL b2b_first latency got %0d want %0d", cyc, WORDS);
    end
    if (cyc > 0) score("b2b_first");
    op_a = 64'hAAAA_AAAA_AAAA_AAAA; op_b = 64'h5555_5555_5555_5556; cin_in = 1'b0;
    sb.push_back(model(op_a, op_b, cin_in));
    wait_done(cyc);
    start = 1'b0;
    checks++;
    if (cyc !== WORDS + 2) begin
      errors++;
      $display("[TB] FAIL b2b_spacing got %0d want %0d", cyc, WORDS + 2);
    end
    if (cyc > 0) score("b2b_second");
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_idle busy got %b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_run();
    op_a = 64'hDEAD_BEEF_CAFE_F00D; op_b = 64'h0123_4567_89AB_CDEF; cin_in = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_outputs busy=%b done=%b result=%h cout=%b ovf=%b want all 0",
               busy, done, result, cout, ovf);
    end
    checks++;
    if (add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_adder a=%h b=%h cin=%b want 0", add_a, add_b, add_cin);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_add(64'h7, 64'h23, 1'b0, "after_abort");
    checks++;
    if (result !== 64'h2A) begin
      errors++;
      $display("[TB] FAIL after_abort_const got %h want 2a", result);
    end
  endtask

  initial begin
    test_reset();
    test_add_vectors();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain left %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
